// File: rtl/rob_pkg.sv
// Shared ROB types: entry layout, register-index widths and retire FSM states.
// The ROB fifo_ram instance and its bench take ROB_ENTRY_WIDTH from here.
package rob_pkg;

    localparam int N_ARCH_REGS     = 32;
    localparam int N_PHYS_REGS     = 64;
    localparam int ARCH_W          = $clog2(N_ARCH_REGS);
    localparam int PHYS_W          = $clog2(N_PHYS_REGS);
    localparam int PC_W            = 32;
    localparam int ROB_ENTRY_WIDTH = 3 + ARCH_W + PHYS_W + PC_W;

    // Field order is MSB to LSB, matching the packed ROB word.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PHYS_W-1:0] phys_rd;
        logic [ARCH_W-1:0] arch_rd;
        logic              has_dest;
        logic              exc;
        logic              done;
    } rob_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } retire_state_t;

endpackage

// File: rtl/rob_retire_ctrl_if.sv
// Head-of-ROB handshake plus the commit bus toward the rename/commit map.
// master = ROB/pipeline side, slave = retire controller.
interface rob_retire_if;
    import rob_pkg::*;

    logic                       head_valid;
    logic [ROB_ENTRY_WIDTH-1:0] head_data;
    logic                       head_ready;
    logic                       stall_i;
    logic                       commit_valid;
    logic                       commit_we;
    logic [ARCH_W-1:0]          commit_arch_rd;
    logic [PHYS_W-1:0]          commit_phys_rd;

    modport master (
        output head_valid, head_data, stall_i,
        input  head_ready, commit_valid, commit_we, commit_arch_rd, commit_phys_rd
    );

    modport slave (
        input  head_valid, head_data, stall_i,
        output head_ready, commit_valid, commit_we, commit_arch_rd, commit_phys_rd
    );

endinterface

// File: rtl/rob_retire_ctrl.sv
// In-order retire controller at the ROB dequeue port: commits done heads, turns an
// excepting head into a registered flush + redirect. RETIRE_PERF_EN adds perf counters.
module rob_retire_ctrl
    import rob_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_aH,
    rob_retire_if.slave       rob,
    output logic              flush_o,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [CNT_W-1:0]  retired_count,
    output logic              busy_flush
`ifdef RETIRE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    retire_state_t    state_q, state_d;
    logic             flush_q, flush_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] retired_count_q, retired_count_d;

    rob_entry_t head;
    logic       active;
    logic       go;
    logic       do_retire;
    logic       do_exc;

    assign head = rob_entry_t'(rob.head_data);

    // Combinational outputs are gated off both in FLUSH and while reset is held.
    assign active    = (state_q == RUN) && !rst_aH;
    assign go        = active && rob.head_valid && head.done && !rob.stall_i;
    assign do_retire = go && !head.exc;
    assign do_exc    = go && head.exc;

    assign rob.head_ready     = go;
    assign rob.commit_valid   = do_retire;
    assign rob.commit_we      = do_retire && head.has_dest && (head.arch_rd != '0);
    assign rob.commit_arch_rd = active ? head.arch_rd : '0;
    assign rob.commit_phys_rd = active ? head.phys_rd : '0;

    assign flush_o       = flush_q;
    assign redirect_pc   = redirect_pc_q;
    assign retired_count = retired_count_q;
    assign busy_flush    = (state_q == FLUSH);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d         = state_q;
        flush_d         = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        retired_count_d = retired_count_q;

        case (state_q)
            RUN: begin
                if (do_exc) begin
                    state_d       = FLUSH;
                    flush_d       = 1'b1;
                    redirect_pc_d = head.pc;
                end
            end
            FLUSH: begin
                // The flush pulse cycle always counts as one FLUSH cycle.
                if (!rob.head_valid && !flush_q) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (do_retire) begin
            retired_count_d = retired_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            state_q         <= RUN;
            flush_q         <= 1'b0;
            redirect_pc_q   <= '0;
            retired_count_q <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            state_q         <= state_d;
            flush_q         <= flush_d;
            redirect_pc_q   <= redirect_pc_d;
            retired_count_q <= retired_count_d;
        end
    end

`ifdef RETIRE_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        // A waiting head: either not finished yet or blocked downstream.
        if ((state_q == RUN) && rob.head_valid && (!head.done || rob.stall_i)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (flush_q) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Scoreboard bench for rob_retire_ctrl; a narrow retired counter makes the wrap reachable.
module tb_rob_retire_ctrl;
    import rob_pkg::*;

    localparam int CNT_W = 4;

    typedef struct {
        logic              we;
        logic [ARCH_W-1:0] arch;
        logic [PHYS_W-1:0] phys;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_aH;
    logic              flush_o;
    logic [PC_W-1:0]   redirect_pc;
    logic [CNT_W-1:0]  retired_count;
    logic              busy_flush;
`ifdef RETIRE_PERF_EN
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;
    logic [CNT_W-1:0]  perf_base;
`endif

    rob_retire_if rob_if ();

    rob_retire_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_aH        (rst_aH),
        .rob           (rob_if),
        .flush_o       (flush_o),
        .redirect_pc   (redirect_pc),
        .retired_count (retired_count),
        .busy_flush    (busy_flush)
`ifdef RETIRE_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
`endif
    );

    always #5 clk = ~clk;

    rob_entry_t       rob_q[$];
    exp_t             exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic             s_hr, s_cv, s_cw;
    logic [CNT_W-1:0] exp_count = '0;

    function automatic rob_entry_t mk(input logic [PC_W-1:0] pc, input int phys, input int arch,
                                      input logic has_dest, input logic exc, input logic done);
        rob_entry_t e;
        e.pc       = pc;
        e.phys_rd  = PHYS_W'(phys);
        e.arch_rd  = ARCH_W'(arch);
        e.has_dest = has_dest;
        e.exc      = exc;
        e.done     = done;
        return e;
    endfunction

    task automatic push(input rob_entry_t e, input bit expect_commit);
        exp_t x;
        rob_q.push_back(e);
        if (expect_commit) begin
            x.we   = e.has_dest && (e.arch_rd != '0);
            x.arch = e.arch_rd;
            x.phys = e.phys_rd;
            exp_q.push_back(x);
        end
    endtask

    task automatic drive();
        rob_if.head_valid = (rob_q.size() > 0);
        rob_if.head_data  = (rob_q.size() > 0) ? rob_q[0] : '1;
    endtask

    // One clock: sample combinational outputs mid-cycle, score commits, retire model head.
    task automatic cycle();
        exp_t x;
        drive();
        @(negedge clk);
        s_hr = rob_if.head_ready;
        s_cv = rob_if.commit_valid;
        s_cw = rob_if.commit_we;
        if (s_cv) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL commit_unexpected: got arch=%0d phys=%0d, required no commit",
                         rob_if.commit_arch_rd, rob_if.commit_phys_rd);
            end else begin
                x = exp_q.pop_front();
                exp_count = exp_count + CNT_W'(1);
                if ({s_cw, rob_if.commit_arch_rd, rob_if.commit_phys_rd} !== {x.we, x.arch, x.phys}) begin
                    n_bad++;
                    $display("FAIL commit_data: got we=%0b arch=%0d phys=%0d, required we=%0b arch=%0d phys=%0d",
                             s_cw, rob_if.commit_arch_rd, rob_if.commit_phys_rd, x.we, x.arch, x.phys);
                end
            end
        end
        @(posedge clk);
        #1;
        if (s_hr && rob_q.size() > 0) void'(rob_q.pop_front());
        drive();
    endtask

    task automatic check_count(input string name);
        n_cmp++;
        if (retired_count !== exp_count || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: got count=%0d pending=%0d, required count=%0d pending=0",
                     name, retired_count, exp_q.size(), exp_count);
        end
    endtask

    task automatic test_reset();
        rst_aH = 1'b1;
        rob_if.stall_i = 1'b0;
        push(mk(32'h100, 1, 1, 1'b1, 1'b0, 1'b1), 1'b0);
        drive();
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if ({rob_if.head_ready, rob_if.commit_valid, flush_o, busy_flush} !== 4'b0000 ||
            redirect_pc !== '0 || retired_count !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got hr=%0b cv=%0b fl=%0b busy=%0b pc=%h cnt=%0d, required all 0",
                     rob_if.head_ready, rob_if.commit_valid, flush_o, busy_flush, redirect_pc, retired_count);
        end
        rob_q.delete();
        drive();
        @(negedge clk);
        rst_aH = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_in_order();
        push(mk(32'h200, 10, 5, 1'b1, 1'b0, 1'b1), 1'b1);
        push(mk(32'h204, 11, 6, 1'b1, 1'b0, 1'b1), 1'b1);
        push(mk(32'h208, 12, 0, 1'b1, 1'b0, 1'b1), 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if ({s_hr, s_cv} !== 2'b11) begin
                n_bad++;
                $display("FAIL in_order_%0d: got hr=%0b cv=%0b, required 1 1", i, s_hr, s_cv);
            end
        end
        cycle();
        n_cmp++;
        if ({s_hr, s_cv} !== 2'b00) begin
            n_bad++;
            $display("FAIL empty_rob: got hr=%0b cv=%0b, required 0 0", s_hr, s_cv);
        end
        check_count("in_order_count");
    endtask

    task automatic test_not_done();
        rob_entry_t e;
`ifdef RETIRE_PERF_EN
        perf_base = stall_cycles;
`endif
        push(mk(32'h300, 20, 7, 1'b1, 1'b0, 1'b0), 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++;
            if ({s_hr, s_cv} !== 2'b00) begin
                n_bad++;
                $display("FAIL not_done_%0d: got hr=%0b cv=%0b, required 0 0", i, s_hr, s_cv);
            end
        end
        e = rob_q[0];
        e.done = 1'b1;
        rob_q[0] = e;
        cycle();
        n_cmp++;
        if ({s_hr, s_cv} !== 2'b11) begin
            n_bad++;
            $display("FAIL done_retire: got hr=%0b cv=%0b, required 1 1", s_hr, s_cv);
        end
        check_count("not_done_count");
`ifdef RETIRE_PERF_EN
        n_cmp++;
        if (stall_cycles - perf_base !== CNT_W'(4)) begin
            n_bad++;
            $display("FAIL stall_cycles_not_done: got +%0d, required +4", stall_cycles - perf_base);
        end
`endif
    endtask

    task automatic test_stall();
        push(mk(32'h400, 21, 8, 1'b0, 1'b0, 1'b1), 1'b1);
        rob_if.stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if ({s_hr, s_cv} !== 2'b00 || retired_count !== exp_count) begin
                n_bad++;
                $display("FAIL stall_%0d: got hr=%0b cv=%0b cnt=%0d, required 0 0 %0d",
                         i, s_hr, s_cv, retired_count, exp_count);
            end
        end
        rob_if.stall_i = 1'b0;
        cycle();
        n_cmp++;
        if ({s_hr, s_cv, s_cw} !== 3'b110) begin
            n_bad++;
            $display("FAIL stall_release: got hr=%0b cv=%0b we=%0b, required 1 1 0", s_hr, s_cv, s_cw);
        end
        check_count("stall_count");
    endtask

    task automatic test_exception();
        push(mk(32'h0000_1A40, 30, 9, 1'b1, 1'b1, 1'b1), 1'b0);
        push(mk(32'h1A44, 31, 10, 1'b1, 1'b0, 1'b1), 1'b0);
        push(mk(32'h1A48, 32, 11, 1'b1, 1'b0, 1'b1), 1'b0);
        rob_if.stall_i = 1'b1;
        cycle();
        n_cmp++;
        if ({s_hr, flush_o, busy_flush} !== 3'b000) begin
            n_bad++;
            $display("FAIL exc_stalled: got hr=%0b fl=%0b busy=%0b, required 0 0 0", s_hr, flush_o, busy_flush);
        end
        rob_if.stall_i = 1'b0;
        cycle();
        n_cmp++;
        if ({s_hr, s_cv} !== 2'b10) begin
            n_bad++;
            $display("FAIL exc_dequeue: got hr=%0b cv=%0b, required 1 0", s_hr, s_cv);
        end
        n_cmp++;
        if ({flush_o, busy_flush} !== 2'b11 || redirect_pc !== 32'h0000_1A40) begin
            n_bad++;
            $display("FAIL exc_flush: got fl=%0b busy=%0b pc=%h, required 1 1 00001a40",
                     flush_o, busy_flush, redirect_pc);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if ({s_hr, s_cv, flush_o, busy_flush} !== 4'b0001) begin
                n_bad++;
                $display("FAIL flush_hold_%0d: got hr=%0b cv=%0b fl=%0b busy=%0b, required 0 0 0 1",
                         i, s_hr, s_cv, flush_o, busy_flush);
            end
        end
        rob_q.delete();
        cycle();
        n_cmp++;
        if (busy_flush !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_exit: got busy=%0b, required 0", busy_flush);
        end
        check_count("exc_count");
`ifdef RETIRE_PERF_EN
        n_cmp++;
        if (flush_count !== CNT_W'(1)) begin
            n_bad++;
            $display("FAIL flush_count: got %0d, required 1", flush_count);
        end
`endif
    endtask

    task automatic test_reset_in_flush();
        push(mk(32'h500, 40, 12, 1'b1, 1'b0, 1'b1), 1'b1);
        push(mk(32'h504, 41, 13, 1'b1, 1'b0, 1'b1), 1'b1);
        repeat (2) cycle();
        n_cmp++;
        if (retired_count !== CNT_W'(7)) begin
            n_bad++;
            $display("FAIL pre_reset_count: got %0d, required 7", retired_count);
        end
        push(mk(32'h508, 42, 14, 1'b1, 1'b1, 1'b1), 1'b0);
        push(mk(32'h50C, 43, 15, 1'b1, 1'b0, 1'b1), 1'b0);
        cycle();
        #2;
        rst_aH = 1'b1;
        #1;
        n_cmp++;
        if ({flush_o, busy_flush, rob_if.head_ready} !== 3'b000 || retired_count !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got fl=%0b busy=%0b hr=%0b cnt=%0d, required 0 0 0 0",
                     flush_o, busy_flush, rob_if.head_ready, retired_count);
        end
        rob_q.delete();
        exp_q.delete();
        exp_count = '0;
        drive();
        @(negedge clk);
        rst_aH = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_wrap();
        int n = (1 << CNT_W) - 1;
        for (int i = 0; i < n; i++) begin
            push(mk(PC_W'(32'h600 + 4 * i), $urandom_range(0, N_PHYS_REGS - 1),
                    $urandom_range(0, N_ARCH_REGS - 1), 1'($urandom_range(0, 1)), 1'b0, 1'b1), 1'b1);
        end
        for (int i = 0; i < n; i++) cycle();
        n_cmp++;
        if (retired_count !== {CNT_W{1'b1}}) begin
            n_bad++;
            $display("FAIL count_max: got %0d, required %0d", retired_count, n);
        end
        push(mk(32'h700, 50, 3, 1'b1, 1'b0, 1'b1), 1'b1);
        cycle();
        n_cmp++;
        if (retired_count !== '0) begin
            n_bad++;
            $display("FAIL count_wrap: got %0d, required 0", retired_count);
        end
        check_count("wrap_count");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rob_if.stall_i    = 1'b0;
        rob_if.head_valid = 1'b0;
        rob_if.head_data  = '0;
        test_reset();
        test_in_order();
        test_not_done();
        test_stall();
        test_exception();
        test_reset_in_flush();
        test_back_to_back_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
